fifo_lane_packer: RTL and testbench

- Consumes the byte stream of the upstream register FIFO (8-bit data plus last flag, 9-bit FIFO word) and packs it little-endian into 64-bit Keccak lanes.
- Applies SHA-3 pad10*1 padding (domain byte, zero fill, 0x80 in the final rate byte) and emits LANES lanes per rate block to the absorb stage.
- Sits directly downstream of the FIFO. It drives fiford and samples fifodout one cycle after each read.

---
 rtl/fifo_lane_packer_pkg.sv | 20 ++
 rtl/fifo_lane_packer.sv | 128 ++++++++++++
 tb/tb_fifo_lane_packer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_lane_packer_pkg.sv
// Shared SHA-3 constants and packer FSM state type.
package fifo_lane_packer_pkg;

    localparam logic [7:0] DOMAIN_SHA3  = 8'h06;
    localparam logic [7:0] DOMAIN_SHAKE = 8'h1F;
    localparam logic [7:0] PAD_FINAL    = 8'h80;

    // Rate in 64-bit lanes per variant.
    localparam int unsigned LANES_SHA3_224 = 18;
    localparam int unsigned LANES_SHA3_256 = 17;
    localparam int unsigned LANES_SHA3_384 = 13;
    localparam int unsigned LANES_SHA3_512 = 9;

    typedef enum logic [1:0] {
        StFill = 2'd0,
        StOut  = 2'd1,
        StPadl = 2'd2
    } state_e;

endpackage

// File: rtl/fifo_lane_packer.sv
// Packs the FIFO byte stream into little-endian 64-bit Keccak lanes and
// appends pad10*1 padding to complete the final rate block.
module fifo_lane_packer
    import fifo_lane_packer_pkg::*;
#(
    parameter int unsigned LANES   = LANES_SHA3_256,
    parameter int unsigned LANEBIT = 5,
    parameter logic [7:0]  DOMAIN  = DOMAIN_SHA3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fifo_notempty,
    output logic               fifo_rd,
    input  logic [8:0]         fifo_dout,
    output logic               lane_vld,
    input  logic               lane_rdy,
    output logic [63:0]        lane_dat,
    output logic [LANEBIT-1:0] lane_idx,
    output logic               lane_last
);

    localparam logic [LANEBIT-1:0] LastLane = LANEBIT'(LANES - 1);

    state_e               state_q, state_d;
    logic [3:0]           byte_cnt_q, byte_cnt_d;
    logic [LANEBIT-1:0]   lane_cnt_q, lane_cnt_d;
    logic                 rd_d1_q;
    logic                 pad_mode_q, pad_mode_d;
    logic                 dom_pend_q, dom_pend_d;
    logic [63:0]          buf_q, buf_d;

    logic                 in_out;
    logic                 final_lane;
    logic [3:0]           fill_lvl;
    logic [2:0]           nxt_pos;

    assign in_out   = (state_q == StOut);
    // A pending domain byte means the pad block is still to come.
    assign final_lane = pad_mode_q & ~dom_pend_q & (lane_cnt_q == LastLane);
    assign fill_lvl = byte_cnt_q + {3'b000, rd_d1_q};
    assign nxt_pos  = byte_cnt_q[2:0] + 3'd1;

    assign fifo_rd = ~rst & (state_q == StFill) & fifo_notempty
                   & ~(rd_d1_q & fifo_dout[8]) & (fill_lvl <= 4'd7);

    always_comb begin
        lane_vld  = in_out;
        lane_dat  = 64'b0;
        lane_idx  = '0;
        lane_last = 1'b0;
        if (in_out) begin
            lane_dat  = buf_q | (final_lane ? {PAD_FINAL, 56'b0} : 64'b0);
            lane_idx  = lane_cnt_q;
            lane_last = final_lane;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        lane_cnt_d = lane_cnt_q;
        pad_mode_d = pad_mode_q;
        dom_pend_d = dom_pend_q;
        buf_d      = buf_q;
        case (state_q)
            StFill: begin
                if (rd_d1_q) begin
                    buf_d[{byte_cnt_q[2:0], 3'b000} +: 8] = fifo_dout[7:0];
                    byte_cnt_d = byte_cnt_q + 4'd1;
                    if (fifo_dout[8]) begin
                        pad_mode_d = 1'b1;
                        if (byte_cnt_q == 4'd7) begin
                            dom_pend_d = 1'b1;
                        end else begin
                            buf_d[{nxt_pos, 3'b000} +: 8] = DOMAIN;
                        end
                        state_d = StOut;
                    end else if (byte_cnt_q == 4'd7) begin
                        state_d = StOut;
                    end
                end
            end
            StOut: begin
                if (lane_rdy) begin
                    buf_d      = 64'b0;
                    byte_cnt_d = 4'd0;
                    lane_cnt_d = (lane_cnt_q == LastLane) ? '0 : lane_cnt_q + LANEBIT'(1);
                    if (!pad_mode_q) begin
                        state_d = StFill;
                    end else if (final_lane) begin
                        pad_mode_d = 1'b0;
                        dom_pend_d = 1'b0;
                        state_d    = StFill;
                    end else begin
                        state_d = StPadl;
                    end
                end
            end
            StPadl: begin
                buf_d      = {56'b0, dom_pend_q ? DOMAIN : 8'h00};
                dom_pend_d = 1'b0;
                state_d    = StOut;
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StFill;
            byte_cnt_q <= 4'd0;
            lane_cnt_q <= '0;
            rd_d1_q    <= 1'b0;
            pad_mode_q <= 1'b0;
            dom_pend_q <= 1'b0;
            buf_q      <= 64'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            lane_cnt_q <= lane_cnt_d;
            rd_d1_q    <= fifo_rd;
            pad_mode_q <= pad_mode_d;
            dom_pend_q <= dom_pend_d;
            buf_q      <= buf_d;
        end
    end

endmodule

// File: tb/tb_fifo_lane_packer.sv
// Directed bench: FIFO model feeds messages, emitted lanes are logged and
// compared against a hand-computed table.
module tb_fifo_lane_packer;
    import fifo_lane_packer_pkg::*;

    localparam int unsigned LANES   = 17;
    localparam int unsigned LANEBIT = 5;
    localparam int          NV      = 17;
    localparam int          NT      = 6;

    logic               clk = 1'b0;
    logic               rst;
    logic               fifo_notempty;
    logic               fifo_rd;
    logic [8:0]         fifo_dout = 9'h0;
    logic               lane_vld;
    logic               lane_rdy;
    logic [63:0]        lane_dat;
    logic [LANEBIT-1:0] lane_idx;
    logic               lane_last;

    int checks   = 0;
    int failures = 0;

    fifo_lane_packer #(
        .LANES   (LANES),
        .LANEBIT (LANEBIT),
        .DOMAIN  (DOMAIN_SHA3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fifo_notempty (fifo_notempty),
        .fifo_rd       (fifo_rd),
        .fifo_dout     (fifo_dout),
        .lane_vld      (lane_vld),
        .lane_rdy      (lane_rdy),
        .lane_dat      (lane_dat),
        .lane_idx      (lane_idx),
        .lane_last     (lane_last)
    );

    always #5 clk = ~clk;

    // Upstream FIFO: data appears one cycle after the read strobe.
    logic [8:0] mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_notempty = (rd_ptr != wr_ptr);

    always @(posedge clk) begin
        if (fifo_rd) begin
            fifo_dout <= mem[rd_ptr[9:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    logic [63:0]        got_dat  [0:511];
    logic [LANEBIT-1:0] got_idx  [0:511];
    logic               got_last [0:511];
    bit                 rd_log   [0:32767];
    int lane_n   = 0;
    int cyc      = 0;
    int rd_total = 0;

    always @(negedge clk) begin
        if (lane_vld && lane_rdy && lane_n < 512) begin
            got_dat[lane_n]  <= lane_dat;
            got_idx[lane_n]  <= lane_idx;
            got_last[lane_n] <= lane_last;
            lane_n           <= lane_n + 1;
        end
        if (cyc < 32768) rd_log[cyc] <= fifo_rd;
        cyc <= cyc + 1;
        if (fifo_rd) rd_total <= rd_total + 1;
    end

    typedef struct {
        int                 tst;
        int                 pos;
        logic [63:0]        dat;
        logic [LANEBIT-1:0] idx;
        logic               last;
    } vec_t;

    vec_t        vecs      [0:NV-1];
    int          msg_len   [0:NT-1] = '{1, 8, 135, 136, 12, 1};
    logic [7:0]  msg_base  [0:NT-1] = '{8'hAB, 8'h01, 8'h01, 8'h01, 8'h01, 8'hCD};
    int          msg_lanes [0:NT-1] = '{17, 17, 17, 34, 17, 17};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_msg(input int len, input logic [7:0] base, input bit last);
        for (int i = 0; i < len; i++) begin
            mem[wr_ptr[9:0]] = {last && (i == len - 1), base + 8'(i)};
            wr_ptr++;
        end
    endtask

    task automatic wait_lanes(input int target, input int budget, input string name);
        int n = 0;
        while (lane_n < target && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk(name, 64'(lane_n >= target), 64'd1);
    endtask

    task automatic run_test(input int t);
        int base = lane_n;
        int rd0  = rd_total;
        int c0   = cyc;
        int run  = 0;
        int best = 0;
        push_msg(msg_len[t], msg_base[t], 1'b1);
        wait_lanes(base + msg_lanes[t], 2000, $sformatf("t%0d lanes arrive", t));
        repeat (20) @(posedge clk);
        #2;
        chk($sformatf("t%0d lane count", t), 64'(lane_n - base), 64'(msg_lanes[t]));
        chk($sformatf("t%0d byte reads", t), 64'(rd_total - rd0), 64'(msg_len[t]));
        if (t == 1) begin
            for (int c = c0; c < cyc && c < 32768; c++) begin
                if (rd_log[c]) begin
                    run++;
                    if (run > best) best = run;
                end else begin
                    run = 0;
                end
            end
            chk("t1 back-to-back reads", 64'(best), 64'd8);
        end
        for (int v = 0; v < NV; v++) begin
            if (vecs[v].tst == t) begin
                chk($sformatf("t%0d lane%0d dat", t, vecs[v].pos),
                    got_dat[base + vecs[v].pos], vecs[v].dat);
                chk($sformatf("t%0d lane%0d idx/last", t, vecs[v].pos),
                    64'({got_idx[base + vecs[v].pos], got_last[base + vecs[v].pos]}),
                    64'({vecs[v].idx, vecs[v].last}));
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;

        vecs[0]  = '{0, 0,  64'h0000_0000_0000_06AB, 5'd0,  1'b0};
        vecs[1]  = '{0, 1,  64'h0,                   5'd1,  1'b0};
        vecs[2]  = '{0, 16, 64'h8000_0000_0000_0000, 5'd16, 1'b1};
        vecs[3]  = '{1, 0,  64'h0807_0605_0403_0201, 5'd0,  1'b0};
        vecs[4]  = '{1, 1,  64'h0000_0000_0000_0006, 5'd1,  1'b0};
        vecs[5]  = '{1, 15, 64'h0,                   5'd15, 1'b0};
        vecs[6]  = '{1, 16, 64'h8000_0000_0000_0000, 5'd16, 1'b1};
        vecs[7]  = '{2, 0,  64'h0807_0605_0403_0201, 5'd0,  1'b0};
        vecs[8]  = '{2, 16, 64'h8687_8685_8483_8281, 5'd16, 1'b1};
        vecs[9]  = '{3, 16, 64'h8887_8685_8483_8281, 5'd16, 1'b0};
        vecs[10] = '{3, 17, 64'h0000_0000_0000_0006, 5'd0,  1'b0};
        vecs[11] = '{3, 18, 64'h0,                   5'd1,  1'b0};
        vecs[12] = '{3, 33, 64'h8000_0000_0000_0000, 5'd16, 1'b1};
        vecs[13] = '{4, 1,  64'h0000_0006_0C0B_0A09, 5'd1,  1'b0};
        vecs[14] = '{4, 16, 64'h8000_0000_0000_0000, 5'd16, 1'b1};
        vecs[15] = '{5, 0,  64'h0000_0000_0000_06CD, 5'd0,  1'b0};
        vecs[16] = '{5, 16, 64'h8000_0000_0000_0000, 5'd16, 1'b1};

        rst      = 1'b1;
        lane_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        lane_rdy = 1'b1;
        @(negedge clk);
        chk("reset dat", lane_dat, 64'h0);
        chk("reset ctl", 64'({lane_vld, fifo_rd, lane_last, lane_idx}), 64'h0);

        for (int t = 0; t < 5; t++) run_test(t);

        // Backpressure on lane 0: data must hold and no read may issue.
        @(posedge clk);
        #1;
        lane_rdy = 1'b0;
        base = lane_n;
        push_msg(10, 8'h10, 1'b1);
        n = 0;
        while (!lane_vld && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("stall lane_vld", 64'(lane_vld), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall lane_dat", lane_dat, 64'h1716_1514_1312_1110);
            chk("stall rd/vld", 64'({fifo_rd, lane_vld, fifo_notempty}), 64'b011);
        end
        @(posedge clk);
        #1;
        lane_rdy = 1'b1;
        wait_lanes(base + 17, 500, "stall lanes arrive");
        repeat (20) @(posedge clk);
        #2;
        chk("stall lane count", 64'(lane_n - base), 64'd17);
        chk("stall lane0 dat", got_dat[base], 64'h1716_1514_1312_1110);
        chk("stall lane1 dat", got_dat[base + 1], 64'h0000_0000_0006_1918);
        chk("stall lane16 last", 64'(got_last[base + 16]), 64'd1);

        // Reset with a partial lane 2 buffered.
        base = lane_n;
        push_msg(19, 8'h20, 1'b0);
        wait_lanes(base + 2, 200, "rst pre lanes arrive");
        n = 0;
        while (rd_ptr != wr_ptr && n < 100) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid-block rst dat", lane_dat, 64'h0);
        chk("mid-block rst ctl", 64'({lane_vld, fifo_rd, lane_last, lane_idx}), 64'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_test(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
